// File: rtl/bcd_to_bin_if.sv
// Request/result bundle for the six-digit BCD to 20-bit binary converter.
interface bcd_to_bin_if;
    logic        start;
    logic [3:0]  unit;
    logic [3:0]  ten;
    logic [3:0]  hun;
    logic [3:0]  tho;
    logic [3:0]  t_tho;
    logic [3:0]  h_hun;
    logic [19:0] data;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, unit, ten, hun, tho, t_tho, h_hun,
        input  data, busy, done, err
    );

    modport slave (
        input  start, unit, ten, hun, tho, t_tho, h_hun,
        output data, busy, done, err
    );
endinterface

// File: rtl/bcd_to_bin.sv
// Six-digit BCD to binary converter: one digit per cycle, MS digit first,
// acc = acc*10 + digit. Result, done and err are registered.
module bcd_to_bin (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    bcd_to_bin_if.slave  bus
);
    typedef enum logic {IDLE, CALC} state_t;

    state_t      state_q, state_d;
    logic [23:0] sr_q, sr_d;
    logic [19:0] acc_q, acc_d;
    logic [19:0] data_q, data_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        digit_bad;
    logic [19:0] acc_next;

    // Any presented digit outside 0..9 makes the request invalid.
    always_comb begin
        digit_bad = (bus.unit  > 4'd9) || (bus.ten   > 4'd9) ||
                    (bus.hun   > 4'd9) || (bus.tho   > 4'd9) ||
                    (bus.t_tho > 4'd9) || (bus.h_hun > 4'd9);
    end

    // acc*10 + top nibble; 999999 fits in 20 bits so no saturation.
    always_comb begin
        acc_next = (acc_q << 3) + (acc_q << 1) + {16'd0, sr_q[23:20]};
    end

    // State and datapath registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: accept/reject in IDLE, six accumulate steps in CALC.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (digit_bad) begin
                        err_d = 1'b1;
                    end else begin
                        sr_d    = {bus.h_hun, bus.t_tho, bus.tho,
                                   bus.hun, bus.ten, bus.unit};
                        acc_d   = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = acc_next;
                sr_d  = {sr_q[19:0], 4'h0};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd5) begin
                    data_d  = acc_next;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.data = data_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: vector table plus scoreboard queue,
// with hand-written sequences for latency, ignored start, reset and streaming.
module tb_bcd_to_bin;
    logic sys_clk;
    logic sys_rst_n;

    bcd_to_bin_if bus ();

    bcd_to_bin dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    typedef struct {
        logic        is_err;
        logic [19:0] data;
    } exp_t;

    typedef struct {
        logic [23:0] bcd;
        logic        exp_err;
        logic [19:0] exp_data;
    } vec_t;

    exp_t sb_q[$];
    int   n_cmp;
    int   n_fail;
    vec_t vecs[8];

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_digits(input logic [23:0] d);
        bus.h_hun = d[23:20];
        bus.t_tho = d[19:16];
        bus.tho   = d[15:12];
        bus.hun   = d[11:8];
        bus.ten   = d[7:4];
        bus.unit  = d[3:0];
    endtask

    // Wait (bounded) until every queued expectation has been consumed.
    task automatic drain(input string name);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 30) begin
            @(negedge sys_clk);
            k++;
        end
        chk({name, "_drain"}, sb_q.size(), 0);
        sb_q.delete();
    endtask

    // Monitor: pop and compare on every done/err pulse.
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (bus.done && bus.err) chk("done_err_overlap", 1, 0);
            if (bus.done || bus.err) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_pulse", {bus.done, bus.err}, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("pulse_kind_err", bus.err, e.is_err);
                    chk("result_data", bus.data, e.data);
                end
            end
        end
    end

    initial begin
        int cyc;
        int got;
        int last_done;

        n_cmp  = 0;
        n_fail = 0;
        vecs[0] = '{24'h005478, 1'b0, 20'd5478};
        vecs[1] = '{24'h000321, 1'b0, 20'd321};
        vecs[2] = '{24'h000078, 1'b0, 20'd78};
        vecs[3] = '{24'h000000, 1'b0, 20'd0};
        vecs[4] = '{24'h999999, 1'b0, 20'd999999};
        vecs[5] = '{24'h123A56, 1'b1, 20'd999999};
        vecs[6] = '{24'h090909, 1'b0, 20'd90909};
        vecs[7] = '{24'hF00000, 1'b1, 20'd90909};

        sys_rst_n = 1'b0;
        bus.start = 1'b0;
        drive_digits(24'h0);
        #12;
        chk("rst_data", bus.data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // Table-driven conversions.
        for (int i = 0; i < 8; i++) begin
            drive_digits(vecs[i].bcd);
            bus.start = 1'b1;
            sb_q.push_back('{vecs[i].exp_err, vecs[i].exp_data});
            @(negedge sys_clk);
            bus.start = 1'b0;
            chk("busy_after_start", bus.busy, !vecs[i].exp_err);
            if (vecs[i].exp_err) chk("err_no_done", bus.done, 0);
            drain("vec");
            @(negedge sys_clk);
        end

        // Latency: busy for k..k+5, done at k+6, with digits changed mid-run.
        drive_digits(24'h987665);
        bus.start = 1'b1;
        sb_q.push_back('{1'b0, 20'd987665});
        for (int i = 0; i < 7; i++) begin
            @(negedge sys_clk);
            bus.start = 1'b0;
            drive_digits(24'h111111);
            chk("lat_busy", bus.busy, (i < 6) ? 1 : 0);
            chk("lat_done", bus.done, (i == 6) ? 1 : 0);
        end
        drain("lat");
        @(negedge sys_clk);

        // Start at k+3 during CALC is ignored.
        drive_digits(24'h004321);
        bus.start = 1'b1;
        sb_q.push_back('{1'b0, 20'd4321});
        @(negedge sys_clk);
        bus.start = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        drive_digits(24'h000555);
        bus.start = 1'b1;
        @(negedge sys_clk);
        bus.start = 1'b0;
        drain("ign");
        repeat (10) @(negedge sys_clk);

        // Mid-conversion reset aborts without a done pulse.
        drive_digits(24'h777777);
        bus.start = 1'b1;
        @(negedge sys_clk);
        bus.start = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_data", bus.data, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        got = 0;
        repeat (10) begin
            @(negedge sys_clk);
            if (bus.done) got++;
        end
        chk("aborted_no_done", got, 0);
        drive_digits(24'h000321);
        bus.start = 1'b1;
        sb_q.push_back('{1'b0, 20'd321});
        @(negedge sys_clk);
        bus.start = 1'b0;
        drain("post_rst");
        @(negedge sys_clk);

        // Start held high: one result every 7 cycles.
        drive_digits(24'h000078);
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) sb_q.push_back('{1'b0, 20'd78});
        got = 0;
        last_done = 0;
        cyc = 0;
        while (got < 3 && cyc < 60) begin
            @(negedge sys_clk);
            cyc++;
            if (bus.done) begin
                got++;
                if (got > 1) chk("stream_period", cyc - last_done, 7);
                last_done = cyc;
                if (got == 3) bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        chk("stream_count", got, 3);
        drain("stream");
        repeat (10) @(negedge sys_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 The block SHALL have a single clock domain. Reset SHALL be asynchronous and active-low.
REQ-002 sys_clk  input  1  rising-edge system clock (50 MHz nominal).
REQ-003 sys_rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  conversion request; sampled only in IDLE.
REQ-005 unit  input  4  BCD digit, 10^0.
REQ-006 ten  input  4  BCD digit, 10^1.
REQ-007 hun  input  4  BCD digit, 10^2.
REQ-008 tho  input  4  BCD digit, 10^3.
REQ-009 t_tho  input  4  BCD digit, 10^4.
REQ-010 h_hun  input  4  BCD digit, 10^5.
REQ-011 data  output  20  binary result, registered, held until next successful conversion.
REQ-012 busy  output  1  high while a conversion is in progress.
REQ-013 done  output  1  one-cycle pulse; data is valid in the same cycle.
REQ-014 err  output  1  one-cycle pulse; a digit > 9 was presented with start.

Function
REQ-015 The FSM SHALL have states IDLE and CALC, with IDLE as the reset state.
REQ-016 IDLE + start at edge k + all digits <= 9: at edge k the block SHALL latch the six digits into a 24-bit shift register (h_hun in the MS nibble), clear the accumulator, clear the 3-bit digit counter, set busy=1, and go to CALC.
REQ-017 IDLE + start at edge k + any digit > 9: at edge k the block SHALL set err=1 for one cycle, stay in IDLE, leave busy=0 and done=0, and leave data unchanged.
REQ-018 In CALC, each edge SHALL perform acc <= acc*10 + top nibble, shift the register left by 4 bits, and increment the counter. Multiply-by-10 SHALL be implemented as (acc<<3)+(acc<<1) with a 20-bit datapath.
REQ-019 The sixth CALC edge (edge k+6) SHALL load data with the final value, set done=1 for one cycle, set busy=0, and return to IDLE. Latency from the start-sampling edge to done SHALL be 6 cycles.
REQ-020 Overflow cannot occur: the maximum value 999999 is below 2^20. No saturation logic SHALL be added.
REQ-021 start SHALL be ignored while busy=1. Digit inputs SHALL NOT be sampled after edge k, so they may change during CALC.
REQ-022 start held high continuously SHALL start a new conversion on the first IDLE edge after done. The resulting throughput is one result per 7 cycles.
REQ-023 done and err SHALL never be high in the same cycle.

Reset
REQ-024 Assertion of sys_rst_n=0 SHALL immediately force the following, including mid-conversion: state=IDLE, data=20'd0, busy=0, done=0, err=0, accumulator=0, counter=0, shift register=0.
REQ-025 After a mid-conversion reset, no done pulse SHALL be produced for the aborted request.
REQ-026 After reset release, the first start sampled SHALL begin a fresh conversion.

Verification
REQ-027 Digits 9,8,7,6,6,5 (h_hun..unit) with start pulse at edge k -> data=20'd987665 and done=1 at edge k+6; busy high for edges k..k+5.
REQ-028 Sequential conversions of 005478, 000321, 000078, 000000, 999999 -> data=5478, 321, 78, 0, 999999 respectively, with one done pulse each.
REQ-029 Digits 1,2,3,A,5,6 with start -> err pulse at edge k; busy stays 0; done stays 0; data keeps its previous value.
REQ-030 Second start pulse at edge k+3 with different digits -> ignored; result equals the first request's value at k+6.
REQ-031 sys_rst_n driven low at edge k+3 and released at k+5 -> outputs zero immediately; no done pulse; a subsequent start of 000321 yields data=321.
REQ-032 start held high with digits 000078 -> done pulses every 7 cycles, with data=78 each time.
